// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle control FSM for an RV32 integer datapath: sequences FETCH/DECODE/EXEC/MEM/WB
// and drives the datapath enables, with a memory-ready timeout, pause request and illegal trap.
module riscv_multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clock,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        mem_ready,
  input  logic        halt_req,
  output logic        ir_load,
  output logic        pc_en,
  output logic        pc_sel_branch,
  output logic [3:0]  alu_op,
  output logic        alu_src_imm,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        wb_sel_mem,
  output logic        illegal,
  output logic        mem_timeout,
  output logic [2:0]  state,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [2:0] {C_R, C_I, C_LW, C_SW, C_BEQ, C_ILL} cls_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(MEM_TIMEOUT);

  state_e           state_q;
  logic [6:0]       opcode_q;
  logic [2:0]       funct3_q;
  logic [6:0]       funct7_q;
  logic [CNT_W-1:0] cnt_q;
  logic             illegal_q;
  logic             mem_timeout_q;
  logic [31:0]      retired_q;

  cls_e             cls;
  logic [3:0]       aop_dec;
  logic             imm_dec;
  logic             unused_instr;

  assign unused_instr = ^{instr[24:15], instr[11:7]};

  always_comb begin
    cls     = C_ILL;
    aop_dec = '0;
    case (opcode_q)
      7'b0110011: begin
        case (funct3_q)
          3'b111: begin cls = C_R; aop_dec = 4'd0; end
          3'b110: begin cls = C_R; aop_dec = 4'd1; end
          3'b000: begin
            if (funct7_q == 7'b0000000) begin cls = C_R; aop_dec = 4'd2; end
            else if (funct7_q == 7'b0100000) begin cls = C_R; aop_dec = 4'd6; end
          end
          default: ;
        endcase
      end
      7'b0010011: begin
        case (funct3_q)
          3'b000: begin cls = C_I; aop_dec = 4'd2; end
          3'b111: begin cls = C_I; aop_dec = 4'd0; end
          3'b110: begin cls = C_I; aop_dec = 4'd1; end
          default: ;
        endcase
      end
      7'b0000011: if (funct3_q == 3'b010) begin cls = C_LW; aop_dec = 4'd2; end
      7'b0100011: if (funct3_q == 3'b010) begin cls = C_SW; aop_dec = 4'd2; end
      7'b1100011: if (funct3_q == 3'b000) begin cls = C_BEQ; aop_dec = 4'd6; end
      default: ;
    endcase
    imm_dec = (cls == C_I) || (cls == C_LW) || (cls == C_SW);
  end

  // Enables are decoded from state and latched fields; gating with rst keeps them low during reset.
  always_comb begin
    ir_load       = 1'b0;
    pc_en         = 1'b0;
    pc_sel_branch = 1'b0;
    alu_op        = '0;
    alu_src_imm   = 1'b0;
    reg_write     = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    wb_sel_mem    = 1'b0;
    if (rst) begin
      case (state_q)
        S_FETCH: ir_load = !halt_req;
        S_EXEC: begin
          alu_op      = aop_dec;
          alu_src_imm = imm_dec;
          if (cls == C_BEQ) begin
            pc_en         = 1'b1;
            pc_sel_branch = alu_zero;
          end
        end
        S_MEM: begin
          alu_op      = aop_dec;
          alu_src_imm = imm_dec;
          mem_read    = (cls == C_LW);
          mem_write   = (cls == C_SW);
          pc_en       = (cls == C_SW) && mem_ready;
        end
        S_WB: begin
          alu_op      = aop_dec;
          alu_src_imm = imm_dec;
          reg_write   = 1'b1;
          wb_sel_mem  = (cls == C_LW);
          pc_en       = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q       <= S_FETCH;
      opcode_q      <= '0;
      funct3_q      <= '0;
      funct7_q      <= '0;
      cnt_q         <= '0;
      illegal_q     <= 1'b0;
      mem_timeout_q <= 1'b0;
      retired_q     <= '0;
    end else begin
      if (pc_en) retired_q <= retired_q + 32'd1;
      case (state_q)
        S_FETCH: begin
          if (!halt_req) begin
            opcode_q <= instr[6:0];
            funct3_q <= instr[14:12];
            funct7_q <= instr[31:25];
            state_q  <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (cls == C_ILL) begin
            illegal_q <= 1'b1;
            state_q   <= S_HALT;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (cls)
            C_R, C_I:   state_q <= S_WB;
            C_LW, C_SW: begin state_q <= S_MEM; cnt_q <= '0; end
            C_BEQ:      state_q <= S_FETCH;
            default:    state_q <= S_HALT;
          endcase
        end
        S_MEM: begin
          // A ready in the final allowed cycle takes priority over the timeout.
          if (mem_ready) begin
            state_q <= (cls == C_LW) ? S_WB : S_FETCH;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
            if ((cnt_q + CNT_ONE) == CNT_TO) begin
              mem_timeout_q <= 1'b1;
              state_q       <= S_HALT;
            end
          end
        end
        S_WB:    state_q <= S_FETCH;
        default: state_q <= S_HALT;
      endcase
    end
  end

  assign illegal     = illegal_q;
  assign mem_timeout = mem_timeout_q;
  assign state       = state_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Scoreboard bench for riscv_multicycle_ctrl: per-cycle expected state/enables/retired queued
// from an instruction-level model, then popped and compared mid-cycle.
module tb_riscv_multicycle_ctrl;

  logic        clock = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr = '0;
  logic        alu_zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        halt_req = 1'b0;
  logic        ir_load, pc_en, pc_sel_branch, alu_src_imm, reg_write;
  logic        mem_read, mem_write, wb_sel_mem, illegal, mem_timeout;
  logic [3:0]  alu_op;
  logic [2:0]  state;
  logic [31:0] retired;
  logic [16:0] obs;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_ret = '0;

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4;

  typedef struct {
    logic [31:0] ins;
    logic        hr, mr, az;
    logic [16:0] v;
    logic [31:0] ret;
  } rec_t;
  rec_t sb[$];
  rec_t e;

  riscv_multicycle_ctrl #(.MEM_TIMEOUT(15), .CNT_W(8)) dut (
    .clock(clock), .rst(rst), .instr(instr), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .halt_req(halt_req), .ir_load(ir_load), .pc_en(pc_en),
    .pc_sel_branch(pc_sel_branch), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .wb_sel_mem(wb_sel_mem), .illegal(illegal), .mem_timeout(mem_timeout),
    .state(state), .retired(retired)
  );

  always #5 clock = ~clock;

  assign obs = {state, ir_load, pc_en, pc_sel_branch, alu_op, alu_src_imm,
                reg_write, mem_read, mem_write, wb_sel_mem, illegal, mem_timeout};

  function automatic logic [16:0] mk(input logic [2:0] st, input logic ir, pce, psb,
                                     input logic [3:0] aop, input logic imm, rw, mrd, mwr,
                                     wbm, ill, mto);
    return {st, ir, pce, psb, aop, imm, rw, mrd, mwr, wbm, ill, mto};
  endfunction

  function automatic void push(input logic [31:0] ins, input logic hr, mr, az,
                               input logic [16:0] v);
    sb.push_back('{ins: ins, hr: hr, mr: mr, az: az, v: v, ret: exp_ret});
  endfunction

  // Expected cycle sequence of one complete instruction; retire bumps exp_ret afterwards.
  function automatic void push_seq(input logic [31:0] ins, input int k, input logic [3:0] aop,
                                   input int waits, input logic az, input logic hr_mid);
    logic imm, beq, lw, sw;
    imm = (k == K_I) || (k == K_LW) || (k == K_SW);
    beq = (k == K_BEQ);
    lw  = (k == K_LW);
    sw  = (k == K_SW);
    push(ins, 1'b0, 1'b0, az, mk(3'd0, 1, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0));
    push(ins, hr_mid, 1'b0, az, mk(3'd1, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0));
    push(ins, hr_mid, 1'b0, az, mk(3'd2, 0, beq, beq & az, aop, imm, 0, 0, 0, 0, 0, 0));
    if (beq) begin exp_ret++; return; end
    if (lw || sw) begin
      for (int i = 0; i < waits; i++)
        push(ins, hr_mid, 1'b0, az, mk(3'd3, 0, 0, 0, aop, imm, 0, lw, sw, 0, 0, 0));
      push(ins, hr_mid, 1'b1, az, mk(3'd3, 0, sw, 0, aop, imm, 0, lw, sw, 0, 0, 0));
      if (sw) begin exp_ret++; return; end
    end
    push(ins, hr_mid, 1'b0, az, mk(3'd4, 0, 1, 0, aop, imm, 1, 0, 0, lw, 0, 0));
    exp_ret++;
  endfunction

  task automatic test_reset();
    #3;
    n_tests++;
    if ({obs, retired} !== {17'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset: ctl=%h retired=%h, want ctl=00000 retired=0", obs, retired);
    end
    @(posedge clock); #1 rst = 1'b1;
    exp_ret = '0;
  endtask

  task automatic test_alu_ops();
    push_seq(32'h002081B3, K_R, 4'd2, 0, 1'b0, 1'b0);  // add
    push_seq(32'h40208033, K_R, 4'd6, 0, 1'b0, 1'b0);  // sub
    push_seq(32'h0020F1B3, K_R, 4'd0, 0, 1'b0, 1'b0);  // and
    push_seq(32'h0020E1B3, K_R, 4'd1, 0, 1'b0, 1'b0);  // or
    push_seq(32'h00500093, K_I, 4'd2, 0, 1'b0, 1'b0);  // addi
    push_seq(32'h0FF0F093, K_I, 4'd0, 0, 1'b0, 1'b0);  // andi
    push_seq(32'h0010E093, K_I, 4'd1, 0, 1'b0, 1'b0);  // ori
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front();
      instr = e.ins; halt_req = e.hr; mem_ready = e.mr; alu_zero = e.az;
      @(negedge clock); n_tests++;
      if ({obs, retired} !== {e.v, e.ret}) begin
        n_fail++;
        $display("FAIL alu_ops[%0d]: ctl=%h ret=%0d, want ctl=%h ret=%0d", i, obs, retired, e.v, e.ret);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_lw_waits();
    push_seq(32'h0080A283, K_LW, 4'd2, 3, 1'b0, 1'b0);
    push_seq(32'h00000463, K_BEQ, 4'd6, 0, 1'b1, 1'b0);
    push_seq(32'h00000463, K_BEQ, 4'd6, 0, 1'b0, 1'b0);
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front();
      instr = e.ins; halt_req = e.hr; mem_ready = e.mr; alu_zero = e.az;
      @(negedge clock); n_tests++;
      if ({obs, retired} !== {e.v, e.ret}) begin
        n_fail++;
        $display("FAIL lw_beq[%0d]: ctl=%h ret=%0d, want ctl=%h ret=%0d", i, obs, retired, e.v, e.ret);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_halt_req();
    for (int i = 0; i < 5; i++)
      push(32'h002081B3, 1'b1, 1'b0, 1'b0, mk(3'd0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0));
    push_seq(32'h002081B3, K_R, 4'd2, 0, 1'b0, 1'b0);
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front();
      instr = e.ins; halt_req = e.hr; mem_ready = e.mr; alu_zero = e.az;
      @(negedge clock); n_tests++;
      if ({obs, retired} !== {e.v, e.ret}) begin
        n_fail++;
        $display("FAIL halt_req[%0d]: ctl=%h ret=%0d, want ctl=%h ret=%0d", i, obs, retired, e.v, e.ret);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_back_to_back();
    push_seq(32'h0080A283, K_LW, 4'd2, 2, 1'b0, 1'b1);   // halt_req held during MEM
    push_seq(32'h0020A023, K_SW, 4'd2, 0, 1'b0, 1'b0);
    push_seq(32'h0020A023, K_SW, 4'd2, 14, 1'b0, 1'b1);  // ready on the last allowed cycle
    push_seq(32'h00500093, K_I, 4'd2, 0, 1'b0, 1'b0);
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front();
      instr = e.ins; halt_req = e.hr; mem_ready = e.mr; alu_zero = e.az;
      @(negedge clock); n_tests++;
      if ({obs, retired} !== {e.v, e.ret}) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: ctl=%h ret=%0d, want ctl=%h ret=%0d", i, obs, retired, e.v, e.ret);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_sw_timeout();
    push(32'h0020A023, 1'b0, 1'b0, 1'b0, mk(3'd0, 1, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0));
    push(32'h0020A023, 1'b0, 1'b0, 1'b0, mk(3'd1, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0));
    push(32'h0020A023, 1'b0, 1'b0, 1'b0, mk(3'd2, 0, 0, 0, 4'd2, 1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 15; i++)
      push(32'h0020A023, 1'b0, 1'b0, 1'b0, mk(3'd3, 0, 0, 0, 4'd2, 1, 0, 0, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      push(32'h0020A023, 1'b0, 1'b1, 1'b1, mk(3'd5, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 1));
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front();
      instr = e.ins; halt_req = e.hr; mem_ready = e.mr; alu_zero = e.az;
      @(negedge clock); n_tests++;
      if ({obs, retired} !== {e.v, e.ret}) begin
        n_fail++;
        $display("FAIL sw_timeout[%0d]: ctl=%h ret=%0d, want ctl=%h ret=%0d", i, obs, retired, e.v, e.ret);
      end
      @(posedge clock); #1;
    end
    rst = 1'b0; #1;
    n_tests++;
    if ({obs, retired} !== {17'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL timeout_reset: ctl=%h retired=%h, want ctl=00000 retired=0", obs, retired);
    end
    @(posedge clock); #1 rst = 1'b1;
    exp_ret = '0;
  endtask

  task automatic test_illegal();
    push(32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, mk(3'd0, 1, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0));
    push(32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, mk(3'd1, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0));
    push(32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, mk(3'd5, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 1, 0));
    push(32'h002081B3, 1'b0, 1'b0, 1'b0, mk(3'd5, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 1, 0));
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front();
      instr = e.ins; halt_req = e.hr; mem_ready = e.mr; alu_zero = e.az;
      @(negedge clock); n_tests++;
      if ({obs, retired} !== {e.v, e.ret}) begin
        n_fail++;
        $display("FAIL illegal[%0d]: ctl=%h ret=%0d, want ctl=%h ret=%0d", i, obs, retired, e.v, e.ret);
      end
      @(posedge clock); #1;
    end
    rst = 1'b0; #1;
    n_tests++;
    if ({obs, retired} !== {17'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL illegal_reset: ctl=%h retired=%h, want ctl=00000 retired=0", obs, retired);
    end
    @(posedge clock); #1 rst = 1'b1;
    exp_ret = '0;
    push_seq(32'h002081B3, K_R, 4'd2, 0, 1'b0, 1'b0);
    push_seq(32'h00000463, K_BEQ, 4'd6, 0, 1'b1, 1'b0);
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front();
      instr = e.ins; halt_req = e.hr; mem_ready = e.mr; alu_zero = e.az;
      @(negedge clock); n_tests++;
      if ({obs, retired} !== {e.v, e.ret}) begin
        n_fail++;
        $display("FAIL resume[%0d]: ctl=%h ret=%0d, want ctl=%h ret=%0d", i, obs, retired, e.v, e.ret);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset_mid_mem();
    push(32'h0080A283, 1'b0, 1'b0, 1'b0, mk(3'd0, 1, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0));
    push(32'h0080A283, 1'b0, 1'b0, 1'b0, mk(3'd1, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0));
    push(32'h0080A283, 1'b0, 1'b0, 1'b0, mk(3'd2, 0, 0, 0, 4'd2, 1, 0, 0, 0, 0, 0, 0));
    push(32'h0080A283, 1'b0, 1'b0, 1'b0, mk(3'd3, 0, 0, 0, 4'd2, 1, 0, 1, 0, 0, 0, 0));
    push(32'h0080A283, 1'b0, 1'b0, 1'b0, mk(3'd3, 0, 0, 0, 4'd2, 1, 0, 1, 0, 0, 0, 0));
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front();
      instr = e.ins; halt_req = e.hr; mem_ready = e.mr; alu_zero = e.az;
      @(negedge clock); n_tests++;
      if ({obs, retired} !== {e.v, e.ret}) begin
        n_fail++;
        $display("FAIL mid_mem[%0d]: ctl=%h ret=%0d, want ctl=%h ret=%0d", i, obs, retired, e.v, e.ret);
      end
      @(posedge clock); #1;
    end
    mem_ready = 1'b1;
    rst = 1'b0; #1;
    n_tests++;
    if ({obs, retired} !== {17'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL mid_mem_reset: ctl=%h retired=%h, want ctl=00000 retired=0", obs, retired);
    end
    @(posedge clock); #1 rst = 1'b1;
    exp_ret = '0;
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_lw_waits();
    test_halt_req();
    test_back_to_back();
    test_sw_timeout();
    test_illegal();
    test_reset_mid_mem();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
